// File: rtl/clock_pkg.sv
// Shared definitions for the front-panel clock-set controller.
// Holds the controller state encoding, field limits, display field codes
// and the wrap-around increment helpers for the hour and minute fields.
package clock_pkg;

    typedef enum logic [2:0] {
        StRun   = 3'd0,
        StTHour = 3'd1,
        StTMin  = 3'd2,
        StAHour = 3'd3,
        StAMin  = 3'd4
    } state_t;

    localparam logic [4:0] MAX_HOUR = 5'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;

    localparam logic [1:0] FIELD_RUN  = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;

    // Wrap by explicit compare; >= also recovers an out-of-range value.
    function automatic logic [4:0] next_hour(input logic [4:0] h);
        return (h >= MAX_HOUR) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [5:0] next_min(input logic [5:0] m);
        return (m >= MAX_MIN) ? 6'd0 : m + 6'd1;
    endfunction

endpackage

// File: rtl/btn_press_rep.sv
// Press detector with optional auto-repeat for one debounced button.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   btn         - debounced button level
//   tick        - auto-repeat rate pulse
//   rep_allow   - auto-repeat permitted (controller is in an edit state)
//   clear       - restart the repeat count (controller state is changing)
//   press       - one-cycle pulse on a rising edge of the registered level
//   step        - press, plus one pulse per tick once the hold delay is met
module btn_press_rep #(
    parameter bit          REPEAT_EN  = 1'b1,
    parameter int unsigned REPEAT_DLY = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic tick,
    input  logic rep_allow,
    input  logic clear,
    output logic press,
    output logic step
);

    localparam logic [3:0] DLY    = 4'(REPEAT_DLY);
    localparam logic [3:0] DLY_M1 = 4'(REPEAT_DLY - 1);

    logic       lvl_q;
    logic       lvl_prev_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       rep_step;
    logic       holding;

    // Reset to 0 so a button held through reset reads as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            lvl_q      <= btn;
            lvl_prev_q <= lvl_q;
            cnt_q      <= cnt_d;
        end
    end

    assign press   = lvl_q & ~lvl_prev_q;
    assign holding = REPEAT_EN & lvl_q & rep_allow;

    // Kept independent of clear: clear is derived from the controller's
    // next state, which itself depends on step.
    assign rep_step = holding & tick & (cnt_q >= DLY_M1);

    always_comb begin
        cnt_d = cnt_q;
        if (!holding || clear) begin
            cnt_d = 4'd0;
        end else if (tick && (cnt_q < DLY)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    assign step = press | rep_step;

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel controller for the HH:MM timekeeper.
// Sequences time-set then alarm-set edits from the mode and inc buttons,
// issues a one-cycle load of the new time, holds the alarm registers and
// enable, and generates the alarm hit pulse.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   tick_1hz, tick_fast    - 1 s pulse (timeout) and auto-repeat pulse
//   btn_mode, btn_inc      - debounced button levels
//   cur_hour, cur_min      - current time from the timekeeper
//   load_time              - one-cycle load strobe for the timekeeper
//   load_hour, load_min    - load value; mirrors the edit buffer otherwise
//   alarm_hour, alarm_min  - committed alarm time
//   alarm_en, alarm_hit    - alarm armed, one-cycle match pulse
//   edit_field, edit_alarm - display select and alarm-edit flag
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S     = 10,
    parameter int unsigned REPEAT_DLY    = 3,
    parameter int unsigned INIT_ALM_HOUR = 7,
    parameter int unsigned INIT_ALM_MIN  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_fast,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic       load_time,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       alarm_en,
    output logic       alarm_hit,
    output logic [1:0] edit_field,
    output logic       edit_alarm
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_S + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

    state_t state_q, state_d;
    logic [4:0] edit_hour_q, edit_hour_d;
    logic [5:0] edit_min_q, edit_min_d;
    logic [4:0] alm_hour_q, alm_hour_d;
    logic [5:0] alm_min_q, alm_min_d;
    logic       alm_en_q, alm_en_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic       load_now;
    logic       load_time_q;
    logic [4:0] load_hour_q;
    logic [5:0] load_min_q;
    logic       match, match_q, hit_q;

    logic mode_press, inc_press, inc_step, in_edit, state_chg;

    assign in_edit   = (state_q != StRun);
    assign state_chg = (state_d != state_q);

    btn_press_rep #(
        .REPEAT_EN  (1'b0),
        .REPEAT_DLY (REPEAT_DLY)
    ) u_mode (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn_mode),
        .tick      (1'b0),
        .rep_allow (1'b0),
        .clear     (1'b0),
        .press     (),
        .step      (mode_press)
    );

    btn_press_rep #(
        .REPEAT_EN  (1'b1),
        .REPEAT_DLY (REPEAT_DLY)
    ) u_inc (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn_inc),
        .tick      (tick_fast),
        .rep_allow (in_edit),
        .clear     (state_chg),
        .press     (inc_press),
        .step      (inc_step)
    );

    always_comb begin
        state_d     = state_q;
        edit_hour_d = edit_hour_q;
        edit_min_d  = edit_min_q;
        alm_hour_d  = alm_hour_q;
        alm_min_d   = alm_min_q;
        alm_en_d    = alm_en_q;
        to_cnt_d    = to_cnt_q;
        load_now    = 1'b0;

        // mode is tested first in every state, so it wins over inc.
        unique case (state_q)
            StRun: begin
                if (mode_press) begin
                    edit_hour_d = cur_hour;
                    edit_min_d  = cur_min;
                    state_d     = StTHour;
                end else if (inc_press) begin
                    alm_en_d = ~alm_en_q;
                end
            end
            StTHour, StAHour: begin
                if (mode_press) begin
                    state_d = (state_q == StTHour) ? StTMin : StAMin;
                end else if (inc_step) begin
                    edit_hour_d = next_hour(edit_hour_q);
                end
            end
            StTMin: begin
                if (mode_press) begin
                    load_now    = 1'b1;
                    edit_hour_d = alm_hour_q;
                    edit_min_d  = alm_min_q;
                    state_d     = StAHour;
                end else if (inc_step) begin
                    edit_min_d = next_min(edit_min_q);
                end
            end
            StAMin: begin
                if (mode_press) begin
                    alm_hour_d = edit_hour_q;
                    alm_min_d  = edit_min_q;
                    state_d    = StRun;
                end else if (inc_step) begin
                    edit_min_d = next_min(edit_min_q);
                end
            end
            default: state_d = StRun;
        endcase

        // Inactivity timeout; a press in the expiring cycle takes priority.
        if (!in_edit || mode_press || inc_press) begin
            to_cnt_d = '0;
        end else if (tick_1hz) begin
            if (to_cnt_q >= TO_LAST) begin
                state_d  = StRun;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
        if (state_d != state_q) begin
            to_cnt_d = '0;
        end
    end

    assign match = (cur_hour == alm_hour_q) && (cur_min == alm_min_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            edit_hour_q <= 5'd0;
            edit_min_q  <= 6'd0;
            alm_hour_q  <= 5'(INIT_ALM_HOUR);
            alm_min_q   <= 6'(INIT_ALM_MIN);
            alm_en_q    <= 1'b0;
            to_cnt_q    <= '0;
            load_time_q <= 1'b0;
            load_hour_q <= 5'd0;
            load_min_q  <= 6'd0;
            match_q     <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_hour_q <= edit_hour_d;
            edit_min_q  <= edit_min_d;
            alm_hour_q  <= alm_hour_d;
            alm_min_q   <= alm_min_d;
            alm_en_q    <= alm_en_d;
            to_cnt_q    <= to_cnt_d;
            load_time_q <= load_now;
            // On the load cycle present the committed time, not the alarm
            // values that are being copied into the edit buffer.
            load_hour_q <= load_now ? edit_hour_q : edit_hour_d;
            load_min_q  <= load_now ? edit_min_q : edit_min_d;
            // Raw compare history, independent of enable, so arming during
            // an existing match does not fire.
            match_q     <= match;
            hit_q       <= alm_en_q && (state_q == StRun) && match && !match_q;
        end
    end

    always_comb begin
        edit_field = FIELD_RUN;
        edit_alarm = 1'b0;
        unique case (state_q)
            StTHour: edit_field = FIELD_HOUR;
            StTMin:  edit_field = FIELD_MIN;
            StAHour: begin
                edit_field = FIELD_HOUR;
                edit_alarm = 1'b1;
            end
            StAMin: begin
                edit_field = FIELD_MIN;
                edit_alarm = 1'b1;
            end
            default: edit_field = FIELD_RUN;
        endcase
    end

    assign load_time  = load_time_q;
    assign load_hour  = load_hour_q;
    assign load_min   = load_min_q;
    assign alarm_hour = alm_hour_q;
    assign alarm_min  = alm_min_q;
    assign alarm_en   = alm_en_q;
    assign alarm_hit  = hit_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed steps, with load and
// alarm-hit events predicted into queues and consumed by a monitor.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_fast = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hour = 5'd12;
    logic [5:0] cur_min = 6'd34;
    logic       load_time;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_en;
    logic       alarm_hit;
    logic [1:0] edit_field;
    logic       edit_alarm;

    int checks = 0;
    int failures = 0;

    logic [10:0] load_q[$];
    int          hit_q[$];

    clock_set_ctrl #(
        .TIMEOUT_S     (10),
        .REPEAT_DLY    (3),
        .INIT_ALM_HOUR (7),
        .INIT_ALM_MIN  (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .tick_fast  (tick_fast),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .load_time  (load_time),
        .load_hour  (load_hour),
        .load_min   (load_min),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_en   (alarm_en),
        .alarm_hit  (alarm_hit),
        .edit_field (edit_field),
        .edit_alarm (edit_alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every load_time / alarm_hit pulse must have been predicted.
    always @(negedge clk) begin
        if (rst_n && load_time) begin
            check("load_expected", 32'(load_q.size() != 0), 32'd1);
            if (load_q.size() != 0) begin
                logic [10:0] e;
                e = load_q.pop_front();
                check("load_value", 32'({load_hour, load_min}), 32'(e));
            end
        end
        if (rst_n && alarm_hit) begin
            check("hit_expected", 32'(hit_q.size() != 0), 32'd1);
            if (hit_q.size() != 0) void'(hit_q.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cyc(3);
        btn_mode = 1'b0;
        cyc(3);
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        cyc(3);
        btn_inc = 1'b0;
        cyc(3);
    endtask

    task automatic pulse_1hz();
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_fast();
        tick_fast = 1'b1;
        cyc(1);
        tick_fast = 1'b0;
        cyc(2);
    endtask

    initial begin
        // Reset state
        cyc(2);
        check("rst_load_time", 32'(load_time), 32'd0);
        check("rst_load_hour", 32'(load_hour), 32'd0);
        check("rst_alarm_hour", 32'(alarm_hour), 32'd7);
        check("rst_alarm_min", 32'(alarm_min), 32'd0);
        check("rst_alarm_en", 32'(alarm_en), 32'd0);
        check("rst_edit_field", 32'(edit_field), 32'd0);
        rst_n = 1'b1;
        cyc(2);
        check("run_edit_alarm", 32'(edit_alarm), 32'd0);

        // Time set 12:34 -> 00:00
        press_mode();
        check("thour_field", 32'(edit_field), 32'd1);
        check("thour_buf_h", 32'(load_hour), 32'd12);
        check("thour_buf_m", 32'(load_min), 32'd34);
        for (int i = 0; i < 11; i++) press_inc();
        check("hour_23", 32'(load_hour), 32'd23);
        press_inc();
        check("hour_wrap", 32'(load_hour), 32'd0);
        press_mode();
        check("tmin_field", 32'(edit_field), 32'd2);
        for (int i = 0; i < 25; i++) press_inc();
        check("min_59", 32'(load_min), 32'd59);
        press_inc();
        check("min_wrap", 32'(load_min), 32'd0);
        load_q.push_back({5'd0, 6'd0});
        press_mode();
        check("load_consumed", 32'(load_q.size()), 32'd0);
        check("ahour_field", 32'(edit_field), 32'd1);
        check("ahour_flag", 32'(edit_alarm), 32'd1);
        check("ahour_buf", 32'(load_hour), 32'd7);

        // Alarm edit 07:00 -> 09:05
        press_inc();
        press_inc();
        press_mode();
        check("amin_field", 32'(edit_field), 32'd2);
        for (int i = 0; i < 5; i++) press_inc();
        press_mode();
        check("alarm_hour", 32'(alarm_hour), 32'd9);
        check("alarm_min", 32'(alarm_min), 32'd5);
        check("back_run", 32'(edit_field), 32'd0);
        check("back_run_flag", 32'(edit_alarm), 32'd0);

        // Timeout
        press_mode();
        press_inc();
        for (int i = 0; i < 9; i++) pulse_1hz();
        check("to_tick9", 32'(edit_field), 32'd1);
        pulse_1hz();
        check("to_tick10", 32'(edit_field), 32'd0);
        check("to_no_commit", 32'(alarm_hour), 32'd9);

        // Press coincident with the expiring tick keeps the edit alive
        press_mode();
        for (int i = 0; i < 9; i++) pulse_1hz();
        btn_inc = 1'b1;
        cyc(1);
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        cyc(2);
        check("to_press_wins", 32'(edit_field), 32'd1);
        check("to_press_inc", 32'(load_hour), 32'd13);
        btn_inc = 1'b0;
        cyc(2);
        for (int i = 0; i < 9; i++) pulse_1hz();
        check("to_restart", 32'(edit_field), 32'd1);
        pulse_1hz();
        check("to_second", 32'(edit_field), 32'd0);

        // Simultaneous mode and inc
        press_mode();
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        cyc(3);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        cyc(3);
        check("sim_field", 32'(edit_field), 32'd2);
        check("sim_hour", 32'(load_hour), 32'd12);

        // Auto-repeat from 05:58
        do_reset();
        cur_hour = 5'd5;
        cur_min = 6'd58;
        press_mode();
        press_mode();
        btn_inc = 1'b1;
        cyc(3);
        check("rep_press", 32'(load_min), 32'd59);
        pulse_fast();
        pulse_fast();
        check("rep_tick2", 32'(load_min), 32'd59);
        pulse_fast();
        check("rep_tick3", 32'(load_min), 32'd0);
        pulse_fast();
        pulse_fast();
        pulse_fast();
        check("rep_tick6", 32'(load_min), 32'd3);
        btn_inc = 1'b0;
        cyc(3);
        pulse_fast();
        pulse_fast();
        check("rep_release", 32'(load_min), 32'd3);
        load_q.push_back({5'd5, 6'd3});
        press_mode();
        check("rep_load", 32'(load_q.size()), 32'd0);

        // Alarm hit
        do_reset();
        cur_hour = 5'd6;
        cur_min = 6'd59;
        cyc(2);
        press_inc();
        check("arm", 32'(alarm_en), 32'd1);
        hit_q.push_back(1);
        cur_hour = 5'd7;
        cur_min = 6'd0;
        cyc(6);
        check("hit_once", 32'(hit_q.size()), 32'd0);
        cur_min = 6'd1;
        cyc(2);
        press_inc();
        check("disarm", 32'(alarm_en), 32'd0);
        cur_hour = 5'd6;
        cur_min = 6'd59;
        cyc(2);
        cur_hour = 5'd7;
        cur_min = 6'd0;
        cyc(6);
        press_inc();
        check("arm_on_match", 32'(alarm_en), 32'd1);
        cyc(4);

        check("load_q_empty", 32'(load_q.size()), 32'd0);
        check("hit_q_empty", 32'(hit_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
